// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the convolution job sequencer.
// Build option CONV_SEQ_PERF_EN (see conv_job_sequencer) does not affect this package.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int WIN_BITS_DEF = 25;
  localparam int RES_W_DEF    = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_seq_fifo.sv
// Generic synchronous FIFO (power-of-2 DEPTH) with full/empty/count status.
// Head entry is presented combinationally on rdata; storage is not reset.
module conv_seq_fifo
  import conv_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/conv_job_sequencer.sv
// Feeds queued 5x5 binary convolution jobs to conv_top one at a time and queues results.
// Define CONV_SEQ_PERF_EN to build the engine-occupancy counter on o_perf_busy_cycles.
module conv_job_sequencer
  import conv_seq_pkg::*;
#(
  parameter int WIN_BITS  = WIN_BITS_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int JOB_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_k_we,
  input  logic [WIN_BITS-1:0] i_cfg_k,
  output logic                o_cfg_err,
  input  logic                i_job_valid,
  input  logic [WIN_BITS-1:0] i_job_x,
  output logic                o_job_ready,
  output logic                o_res_valid,
  output logic [RES_W-1:0]    o_res,
  input  logic                i_res_ready,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_jobs_done,
  output logic [CNT_W-1:0]    o_perf_busy_cycles,
  output logic                o_eng_valid,
  output logic [WIN_BITS-1:0] o_eng_x,
  output logic [WIN_BITS-1:0] o_eng_k,
  input  logic                i_eng_ready,
  input  logic                i_eng_valid,
  input  logic [RES_W-1:0]    i_eng_conv,
  output logic                o_eng_ready
);

  localparam int JCW = ptr_w(JOB_DEPTH) + 1;
  localparam int RCW = ptr_w(RES_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [WIN_BITS-1:0] kernel_q, kernel_d;
  logic                cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]    jobs_done_q, jobs_done_d;

  logic                job_push, job_pop, job_full, job_empty;
  logic [JCW-1:0]      job_count;
  logic [WIN_BITS-1:0] job_head;
  logic                res_push, res_pop, res_full, res_empty;
  logic [RCW-1:0]      res_count;
  logic [RES_W-1:0]    res_head;
  logic                inflight, credit, k_we_ok;
  logic [RCW:0]        occupancy;

  assign job_push = i_job_valid & o_job_ready;
  assign job_pop  = o_eng_valid & i_eng_ready;
  assign res_push = o_eng_ready & i_eng_valid;
  assign res_pop  = o_res_valid & i_res_ready;

  conv_seq_fifo #(.WIDTH(WIN_BITS), .DEPTH(JOB_DEPTH)) u_job_fifo (
    .clk(i_clk), .rst(i_rst), .push(job_push), .wdata(i_job_x), .pop(job_pop),
    .rdata(job_head), .full(job_full), .empty(job_empty), .count(job_count)
  );

  conv_seq_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk(i_clk), .rst(i_rst), .push(res_push), .wdata(i_eng_conv), .pop(res_pop),
    .rdata(res_head), .full(res_full), .empty(res_empty), .count(res_count)
  );

  // Queued results plus the one outstanding job must fit in the result FIFO,
  // so the engine's output handshake never has to be throttled.
  assign inflight  = (state_q != ST_IDLE);
  assign occupancy = {1'b0, res_count} + {{RCW{1'b0}}, inflight};
  assign credit    = ~res_full & (occupancy < (RCW+1)'(RES_DEPTH));
  assign k_we_ok   = (state_q == ST_IDLE) & job_empty;

  always_comb begin
    state_d     = state_q;
    kernel_d    = kernel_q;
    cfg_err_d   = cfg_err_q;
    jobs_done_d = jobs_done_q + CNT_W'(res_push);
    case (state_q)
      ST_IDLE:  if (!job_empty && credit) state_d = ST_ISSUE;
      ST_ISSUE: if (i_eng_ready) state_d = ST_WAIT;
      ST_WAIT:  if (i_eng_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (i_cfg_k_we) begin
      if (k_we_ok) kernel_d  = i_cfg_k;
      else         cfg_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      kernel_q    <= '0;
      cfg_err_q   <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      kernel_q    <= kernel_d;
      cfg_err_q   <= cfg_err_d;
      jobs_done_q <= jobs_done_d;
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [CNT_W-1:0] perf_q, perf_d;

  assign perf_d = perf_q + CNT_W'(inflight);

  always_ff @(posedge i_clk) begin
    if (i_rst) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign o_perf_busy_cycles = perf_q;
`else
  assign o_perf_busy_cycles = '0;
`endif

  // Engine-side strobes decode registered state only; data is gated to zero
  // outside ISSUE so nothing stale leaks out after reset.
  assign o_eng_valid = (state_q == ST_ISSUE);
  assign o_eng_ready = (state_q == ST_WAIT);
  assign o_eng_x     = o_eng_valid ? job_head : '0;
  assign o_eng_k     = o_eng_valid ? kernel_q : '0;

  assign o_job_ready = ~job_full;
  assign o_res_valid = ~res_empty;
  assign o_res       = res_empty ? '0 : res_head;
  assign o_busy      = inflight | (job_count != '0);
  assign o_cfg_err   = cfg_err_q;
  assign o_jobs_done = jobs_done_q;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed self-checking bench for conv_job_sequencer with a small engine model.
// Perf-counter expectation follows CONV_SEQ_PERF_EN.
module tb_conv_job_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cfg_k_we;
  logic [24:0] i_cfg_k;
  logic        o_cfg_err;
  logic        i_job_valid;
  logic [24:0] i_job_x;
  logic        o_job_ready;
  logic        o_res_valid;
  logic [1:0]  o_res;
  logic        i_res_ready;
  logic        o_busy;
  logic [31:0] o_jobs_done;
  logic [31:0] o_perf_busy_cycles;
  logic        o_eng_valid;
  logic [24:0] o_eng_x;
  logic [24:0] o_eng_k;
  logic        i_eng_ready;
  logic        i_eng_valid;
  logic [1:0]  i_eng_conv;
  logic        o_eng_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // engine model controls
  int         rdy_lat = 1;
  int         res_lat = 1;
  logic       eng_stall = 1'b0;
  logic       fix_en = 1'b0;
  logic [1:0] fix_val = 2'b00;
  logic       eng_man = 1'b0;
  logic       man_ready = 1'b0;
  logic       man_valid = 1'b0;
  logic [1:0] man_conv = 2'b00;

  conv_job_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_k_we(i_cfg_k_we), .i_cfg_k(i_cfg_k), .o_cfg_err(o_cfg_err),
    .i_job_valid(i_job_valid), .i_job_x(i_job_x), .o_job_ready(o_job_ready),
    .o_res_valid(o_res_valid), .o_res(o_res), .i_res_ready(i_res_ready),
    .o_busy(o_busy), .o_jobs_done(o_jobs_done), .o_perf_busy_cycles(o_perf_busy_cycles),
    .o_eng_valid(o_eng_valid), .o_eng_x(o_eng_x), .o_eng_k(o_eng_k),
    .i_eng_ready(i_eng_ready), .i_eng_valid(i_eng_valid), .i_eng_conv(i_eng_conv),
    .o_eng_ready(o_eng_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return o_eng_valid;
      1:       return o_eng_ready;
      2:       return o_res_valid;
      3:       return ~o_busy;
      default: return o_job_ready;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input int budget);
    int n;
    n = 0;
    while (!cond(sel) && n < budget) begin
      tick();
      n++;
    end
    chk_eq(tag, {31'd0, cond(sel)}, 32'd1);
  endtask

  task automatic push_job(input logic [24:0] x);
    i_job_valid = 1'b1;
    i_job_x     = x;
    wait_until("push_rdy", 4, 200);
    tick();
    i_job_valid = 1'b0;
  endtask

  // Engine model: ready after rdy_lat ISSUE cycles, result after res_lat WAIT cycles.
  initial begin : engine_model
    int rdy_cnt;
    int res_cnt;
    logic [24:0] cap_x;
    rdy_cnt = 0;
    res_cnt = 0;
    cap_x = '0;
    i_eng_ready = 1'b0;
    i_eng_valid = 1'b0;
    i_eng_conv  = 2'b00;
    forever begin
      @(posedge i_clk);
      #2;
      if (o_eng_valid) begin
        rdy_cnt++;
        cap_x = o_eng_x;
      end else begin
        rdy_cnt = 0;
      end
      if (o_eng_ready) res_cnt++;
      else             res_cnt = 0;
      if (eng_man) begin
        i_eng_ready = man_ready;
        i_eng_valid = man_valid;
        i_eng_conv  = man_conv;
      end else begin
        i_eng_ready = o_eng_valid && !eng_stall && (rdy_cnt >= rdy_lat);
        i_eng_valid = o_eng_ready && (res_cnt >= res_lat);
        i_eng_conv  = fix_en ? fix_val : cap_x[1:0];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [24:0] xs [6];
    logic [1:0]  exp_res [6];
    int npop;
    int cyc;

    i_rst = 1'b1;
    i_cfg_k_we = 1'b0;
    i_cfg_k = '0;
    i_job_valid = 1'b0;
    i_job_x = '0;
    i_res_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;

    // reset state
    chk_eq("rst_job_ready", {31'd0, o_job_ready}, 32'd1);
    chk_eq("rst_eng_valid", {31'd0, o_eng_valid}, 32'd0);
    chk_eq("rst_eng_ready", {31'd0, o_eng_ready}, 32'd0);
    chk_eq("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
    chk_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    chk_eq("rst_cfg_err", {31'd0, o_cfg_err}, 32'd0);
    chk_eq("rst_jobs_done", o_jobs_done, 32'd0);
    chk_eq("rst_perf", o_perf_busy_cycles, 32'd0);
    chk_eq("rst_eng_x", {7'd0, o_eng_x}, 32'd0);
    chk_eq("rst_res", {30'd0, o_res}, 32'd0);

    // single job: kernel all ones, fixed result 2'b10 after 3 WAIT cycles
    rdy_lat = 1; res_lat = 3; fix_en = 1'b1; fix_val = 2'b10;
    i_cfg_k_we = 1'b1; i_cfg_k = 25'h1FFFFFF;
    tick();
    i_cfg_k_we = 1'b0;
    i_job_valid = 1'b1; i_job_x = 25'h0155555;
    tick();
    i_job_valid = 1'b0;
    chk_eq("lat_not_yet", {31'd0, o_eng_valid}, 32'd0);
    chk_eq("busy_queued", {31'd0, o_busy}, 32'd1);
    tick();
    chk_eq("lat_issue", {31'd0, o_eng_valid}, 32'd1);
    chk_eq("issue_x", {7'd0, o_eng_x}, 32'h0155555);
    chk_eq("issue_k", {7'd0, o_eng_k}, 32'h1FFFFFF);
    tick();
    chk_eq("wait_ready", {31'd0, o_eng_ready}, 32'd1);
    wait_until("res1_wait", 2, 20);
    chk_eq("res1_val", {30'd0, o_res}, 32'd2);
    chk_eq("res1_done", o_jobs_done, 32'd1);
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk_eq("res1_popped", {31'd0, o_res_valid}, 32'd0);
    fix_en = 1'b0;

    // stalled engine: four pushes fill the job FIFO, fifth is refused
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    eng_stall = 1'b1;
    xs = '{25'h0000011, 25'h0000022, 25'h0000033, 25'h0000044, 25'h0000055, 25'h0};
    i_job_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_job_x = xs[i];
      chk_eq("fill_ready", {31'd0, o_job_ready}, 32'd1);
      tick();
    end
    i_job_x = xs[4];
    for (int i = 0; i < 3; i++) begin
      chk_eq("full_ready", {31'd0, o_job_ready}, 32'd0);
      chk_eq("stall_valid", {31'd0, o_eng_valid}, 32'd1);
      chk_eq("stall_x", {7'd0, o_eng_x}, {7'd0, xs[0]});
      tick();
    end
    i_job_valid = 1'b0;
    eng_stall = 1'b0;
    i_res_ready = 1'b1;
    wait_until("stall_drain", 3, 200);
    chk_eq("stall_done", o_jobs_done, 32'd4);
    tick();
    i_res_ready = 1'b0;

    // credit: six jobs, host not popping -> only four results may be in flight
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    xs = '{25'h0000100, 25'h0000201, 25'h0000302, 25'h0000403, 25'h0000501, 25'h0000602};
    exp_res = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    for (int i = 0; i < 6; i++) push_job(xs[i]);
    for (int i = 0; i < 40; i++) tick();
    chk_eq("credit_done", o_jobs_done, 32'd4);
    chk_eq("credit_no_issue", {31'd0, o_eng_valid}, 32'd0);
    chk_eq("credit_busy", {31'd0, o_busy}, 32'd1);
    chk_eq("credit_res_valid", {31'd0, o_res_valid}, 32'd1);
    i_res_ready = 1'b1;
    npop = 0;
    cyc = 0;
    while (npop < 6 && cyc < 300) begin
      if (o_res_valid) begin
        chk_eq("drain_order", {30'd0, o_res}, {30'd0, exp_res[npop]});
        npop++;
      end
      tick();
      cyc++;
    end
    chk_eq("drain_count", npop, 32'd6);
    chk_eq("drain_done", o_jobs_done, 32'd6);
    i_res_ready = 1'b0;

    // kernel write while a job is in WAIT is rejected
    i_cfg_k_we = 1'b1; i_cfg_k = 25'h0AAAAAA;
    tick();
    i_cfg_k_we = 1'b0;
    chk_eq("kwr_ok_err", {31'd0, o_cfg_err}, 32'd0);
    res_lat = 4;
    push_job(25'h0000123);
    wait_until("kwr_wait", 1, 20);
    i_cfg_k_we = 1'b1; i_cfg_k = 25'h1234567;
    tick();
    i_cfg_k_we = 1'b0;
    chk_eq("kwr_err", {31'd0, o_cfg_err}, 32'd1);
    i_res_ready = 1'b1;
    wait_until("kwr_idle1", 3, 50);
    push_job(25'h0000456);
    wait_until("kwr_issue", 0, 20);
    chk_eq("kwr_old_k", {7'd0, o_eng_k}, 32'h0AAAAAA);
    wait_until("kwr_idle2", 3, 50);
    tick();
    i_res_ready = 1'b0;
    chk_eq("kwr_err_sticky", {31'd0, o_cfg_err}, 32'd1);

    // reset during WAIT abandons the job; a late engine result is dropped
    eng_man = 1'b1; man_ready = 1'b1; man_valid = 1'b0;
    push_job(25'h0000777);
    wait_until("rstw_wait", 1, 20);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_eq("rstw_eng_ready", {31'd0, o_eng_ready}, 32'd0);
    chk_eq("rstw_eng_valid", {31'd0, o_eng_valid}, 32'd0);
    chk_eq("rstw_res_valid", {31'd0, o_res_valid}, 32'd0);
    chk_eq("rstw_done", o_jobs_done, 32'd0);
    chk_eq("rstw_job_ready", {31'd0, o_job_ready}, 32'd1);
    chk_eq("rstw_cfg_err", {31'd0, o_cfg_err}, 32'd0);
    man_valid = 1'b1; man_conv = 2'b11;
    tick();
    tick();
    man_valid = 1'b0;
    tick();
    chk_eq("late_res_valid", {31'd0, o_res_valid}, 32'd0);
    chk_eq("late_done", o_jobs_done, 32'd0);
    chk_eq("late_busy", {31'd0, o_busy}, 32'd0);
    eng_man = 1'b0; man_ready = 1'b0;

    // perf counter: 2 ISSUE cycles + 5 WAIT cycles
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    rdy_lat = 2; res_lat = 5;
    push_job(25'h0000001);
    tick();
    wait_until("perf_idle", 3, 50);
    chk_eq("perf_done", o_jobs_done, 32'd1);
`ifdef CONV_SEQ_PERF_EN
    chk_eq("perf_cycles", o_perf_busy_cycles, 32'd7);
`else
    chk_eq("perf_cycles", o_perf_busy_cycles, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_job_sequencer.md
Name: conv_job_sequencer

Overview:
- Sequences 5x5 binary convolution jobs into the serial-multiply convolution engine (conv_top).
- Host side: a kernel register, a job queue of X windows, and a result queue of 2-bit conv outputs, all behind valid/ready handshakes.
- Engine side: drives the engine's valid/ready handshake, one job outstanding at a time, plus a completed-job counter.
- Sits between the HPS PIO bridge logic and conv_top, so software no longer single-steps the handshake.

Parameters:
- WIN_BITS, 25, bits per X window and per kernel (5x5).
- RES_W, 2, engine result width.
- JOB_DEPTH, 4, job FIFO entries (power of 2, >=2).
- RES_DEPTH, 4, result FIFO entries (power of 2, >=2).
- CNT_W, 32, counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cfg_k_we  in  1  kernel write strobe.
- i_cfg_k  in  WIN_BITS  kernel value.
- o_cfg_err  out  1  sticky: a kernel write was rejected.
- i_job_valid  in  1  host job valid.
- i_job_x  in  WIN_BITS  X window.
- o_job_ready  out  1  job FIFO not full.
- o_res_valid  out  1  result FIFO not empty.
- o_res  out  RES_W  head result.
- i_res_ready  in  1  host pops a result.
- o_busy  out  1  FSM not IDLE, or job FIFO non-empty.
- o_jobs_done  out  CNT_W  completed jobs.
- o_perf_busy_cycles  out  CNT_W  engine-occupied cycles (optional feature).
- o_eng_valid  out  1  to engine i_valid.
- o_eng_x  out  WIN_BITS  to engine i_bit_X.
- o_eng_k  out  WIN_BITS  to engine i_bit_K.
- i_eng_ready  in  1  from engine o_ready.
- i_eng_valid  in  1  from engine o_valid.
- i_eng_conv  in  RES_W  from engine o_conv.
- o_eng_ready  out  1  to engine i_ready.

Behaviour:
- Reset (i_rst high at an edge):
  - Both FIFOs are flushed; FSM goes to IDLE; kernel register, o_cfg_err and all counters are cleared.
  - All outputs are 0 after that edge, except o_job_ready, which is 1.
  - Applies mid-job: the in-flight job is abandoned and any later engine result is not captured. The engine is reset separately by the system.
- Job FIFO:
  - Push on i_job_valid & o_job_ready. o_job_ready = !full; a push when full is not possible.
  - Pop occurs on the engine input handshake.
  - Pointers wrap modulo JOB_DEPTH. There is no bypass: a job pushed at edge E is visible to the FSM after E.
- Result FIFO:
  - Push on the engine output handshake; pop on o_res_valid & i_res_ready.
  - Simultaneous push and pop is legal: count unchanged, order preserved.
  - o_res = head entry; it is stable while o_res_valid & !i_res_ready.
- Credit rule:
  - A job may be issued only if the result FIFO count plus the in-flight job is less than RES_DEPTH.
  - This guarantees a result is never dropped and o_eng_ready is never throttled.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE at the edge where the job FIFO is non-empty and credit is available.
  - ISSUE:
    - o_eng_valid = 1; o_eng_x = job FIFO head; o_eng_k = kernel register.
    - Held stable until i_eng_ready.
    - On handshake (o_eng_valid & i_eng_ready): pop the job and go to WAIT.
  - WAIT:
    - o_eng_ready = 1.
    - On i_eng_valid: push i_eng_conv into the result FIFO, increment o_jobs_done, go to IDLE.
  - o_eng_valid and o_eng_ready are decodes of registered state only; no combinational path from inputs.
- Latency:
  - Job accepted at edge E0 into an idle, empty block: o_eng_valid is high in the cycle after E1.
  - Engine result at edge E: o_res_valid is high in the cycle after E.
  - Back-to-back jobs: minimum one IDLE cycle between jobs.
- Kernel write:
  - Accepted only when FSM is IDLE and the job FIFO is empty.
  - Otherwise the write is ignored and o_cfg_err is set; it is cleared only by reset.
  - The kernel is sampled by the engine during ISSUE only.
- Counters: o_jobs_done wraps modulo 2^CNT_W.
- Engine signals outside their states:
  - i_eng_valid outside WAIT is ignored.
  - i_eng_ready outside ISSUE is ignored.

Optional Feature:
- Macro: CONV_SEQ_PERF_EN.
- Defined: o_perf_busy_cycles increments every cycle the FSM is in ISSUE or WAIT. It wraps, and is cleared by reset.
- Undefined: o_perf_busy_cycles is tied to 0 and no counter is synthesized.

Decomposition:
- Package conv_seq_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - default widths WIN_BITS=25 and RES_W=2;
  - the FIFO pointer-width function clog2-based.
- One sub-module: conv_seq_fifo, a generic synchronous FIFO with parameters WIDTH and DEPTH and outputs full, empty and count. It is instantiated twice, as the job FIFO and the result FIFO.

Test Plan:
- Reset, write kernel 25'h1FFFFFF, push one job 25'h0155555; engine model with ready=1 and result after 3 cycles = 2'b10.
  - o_eng_x = 25'h0155555 and o_eng_k = 25'h1FFFFFF during ISSUE; o_res = 2'b10; o_jobs_done = 1.
- Push 4 jobs with the engine stalled (i_eng_ready=0).
  - o_job_ready drops after 4 accepted pushes; a 5th push is not accepted; o_eng_valid and o_eng_x are held stable.
- i_res_ready=0 with 6 jobs queued.
  - Exactly 4 results accumulate and no 5th issue occurs (credit rule).
  - Then raise i_res_ready: all 6 results drain in order; o_jobs_done = 6.
- Kernel write while in WAIT.
  - Kernel unchanged; o_cfg_err = 1; later jobs still use the old kernel.
- Assert i_rst for 1 cycle while in WAIT.
  - Next cycle: state IDLE, o_eng_ready = 0, o_res_valid = 0, o_jobs_done = 0, o_job_ready = 1; a late i_eng_valid produces no result.
- With CONV_SEQ_PERF_EN defined: a single job with engine ready latency 2 and result latency 5.
  - o_perf_busy_cycles equals the number of ISSUE+WAIT cycles (7 for this model).
  - With the macro undefined, the output is constant 0.
